// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - debounced button input to per-frame clamped player position
// Position steps once per VS rising edge with a SLOW->FAST speed ramp.
module player_motion_ctrl #(
  parameter int SIZE        = 40,
  parameter int START_X     = 300,
  parameter int START_Y     = 220,
  parameter int SLOW_STEP   = 1,
  parameter int FAST_STEP   = 4,
  parameter int RAMP_FRAMES = 8,
  parameter int DB_CYCLES   = 250000,
  parameter int DB_W        = 18
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        vs,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic        frame_tick,
  output logic        moving
);

  localparam int RW = $clog2(RAMP_FRAMES + 1);
  localparam logic [10:0] X_MAX = 11'(640 - SIZE);
  localparam logic [10:0] Y_MAX = 11'(480 - SIZE);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  // Button bit order: 0=up, 1=down, 2=left, 3=right
  logic [3:0]      raw, sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [4];

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic          vs_d;
  logic          frame_edge;
  logic          up_only, down_only, left_only, right_only, any_move;
  state_t        state, nstate;
  logic [RW-1:0] ramp, nramp;
  logic [11:0]   step, sx, sy;
  logic [10:0]   next_x, next_y;

  assign frame_edge = vs & ~vs_d;
  assign up_only    = db[0] & ~db[1];
  assign down_only  = db[1] & ~db[0];
  assign left_only  = db[2] & ~db[3];
  assign right_only = db[3] & ~db[2];
  assign any_move   = up_only | down_only | left_only | right_only;

  // Step size follows the post-transition state, so entering IDLE moves nothing
  always_comb begin
    nstate = state;
    nramp  = ramp;
    case (state)
      IDLE: if (any_move) begin
        nstate = SLOW;
        nramp  = '0;
      end
      SLOW: if (!any_move) begin
        nstate = IDLE;
      end else if (ramp == RW'(RAMP_FRAMES - 1)) begin
        nstate = FAST;
      end else begin
        nramp = ramp + 1'b1;
      end
      FAST: if (!any_move) begin
        nstate = IDLE;
        nramp  = '0;
      end
      default: nstate = IDLE;
    endcase

    case (nstate)
      SLOW:    step = 12'(SLOW_STEP);
      FAST:    step = 12'(FAST_STEP);
      default: step = '0;
    endcase

    sx = {1'b0, player_x};
    if (right_only)     sx = sx + step;
    else if (left_only) sx = sx - step;
    sy = {1'b0, player_y};
    if (down_only)      sy = sy + step;
    else if (up_only)   sy = sy - step;

    if ($signed(sx) < 12'sd0)                     next_x = '0;
    else if ($signed(sx) > $signed({1'b0, X_MAX})) next_x = X_MAX;
    else                                          next_x = sx[10:0];
    if ($signed(sy) < 12'sd0)                     next_y = '0;
    else if ($signed(sy) > $signed({1'b0, Y_MAX})) next_y = Y_MAX;
    else                                          next_y = sy[10:0];
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
      state      <= IDLE;
      ramp       <= '0;
      moving     <= 1'b0;
      player_x   <= 11'(START_X);
      player_y   <= 11'(START_Y);
    end else begin
      vs_d       <= vs;
      frame_tick <= frame_edge;
      if (frame_edge) begin
        state    <= nstate;
        ramp     <= nramp;
        moving   <= (nstate != IDLE);
        player_x <= next_x;
        player_y <= next_y;
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - scoreboard bench for player_motion_ctrl
module tb_player_motion_ctrl;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        vs = 1'b1;
  logic [10:0] player_x, player_y;
  logic        frame_tick, moving;

  int checks = 0;
  int errors = 0;
  int ex, ey;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        m;
  } exp_t;
  exp_t exp_q[$];

  player_motion_ctrl #(.DB_CYCLES(4), .RAMP_FRAMES(8)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .vs        (vs),
    .player_x  (player_x),
    .player_y  (player_y),
    .frame_tick(frame_tick),
    .moving    (moving)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every frame_tick must match the oldest queued expectation
  always @(negedge pixel_clk) begin
    if (frame_tick) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick at x=%0d y=%0d expected none", player_x, player_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_x", int'(player_x), int'(e.x));
        chk("frame_y", int'(player_y), int'(e.y));
        chk("frame_moving", int'(moving), int'(e.m));
      end
    end
  end

  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    repeat (20) @(posedge pixel_clk);
    #1;
  endtask

  task automatic frame(input int x, input int y, input logic m);
    exp_q.push_back('{x: 11'(x), y: 11'(y), m: m});
    vs = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 vs = 1'b1;
    repeat (4) @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with buttons high and vs toggling
    btn_up = 1; btn_down = 1; btn_left = 1; btn_right = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge pixel_clk); #1 vs = ~vs;
    end
    vs = 1'b1;
    #1;
    chk("rst_x", int'(player_x), 300);
    chk("rst_y", int'(player_y), 220);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_moving", int'(moving), 0);
    @(posedge pixel_clk); #1 rst_n = 1'b1;
    set_btn(1, 1, 1, 1);
    set_btn(0, 0, 0, 0);

    // 3-cycle glitch never propagates
    btn_right = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1 btn_right = 1'b0;
    repeat (20) @(posedge pixel_clk);
    #1;
    frame(300, 220, 0);

    // Ramp: 8 slow frames then fast
    set_btn(0, 0, 0, 1);
    ex = 300; ey = 220;
    for (int k = 0; k < 12; k++) begin
      ex = ex + ((k < 8) ? 1 : 4);
      frame(ex, ey, 1);
    end
    set_btn(0, 0, 0, 0);
    frame(324, 220, 0);
    frame(324, 220, 0);

    // Conflict then diagonal
    set_btn(0, 0, 1, 1);
    frame(324, 220, 0);
    set_btn(0, 1, 0, 1);
    frame(325, 221, 1);
    frame(326, 222, 1);
    set_btn(0, 0, 0, 0);
    frame(326, 222, 0);

    // X clamp: reach 598 in FAST, then 600 and hold
    set_btn(0, 0, 0, 1);
    ex = 326; ey = 222;
    for (int k = 0; k < 8; k++) begin ex++; frame(ex, ey, 1); end
    while (ex < 598) begin ex += 4; frame(ex, ey, 1); end
    frame(600, 222, 1);
    frame(600, 222, 1);
    set_btn(0, 0, 0, 0);
    frame(600, 222, 0);

    // Y clamp: reach 2 in FAST, then 0 with no wrap
    set_btn(1, 0, 0, 0);
    ex = 600; ey = 222;
    for (int k = 0; k < 8; k++) begin ey--; frame(ex, ey, 1); end
    while (ey > 2) begin ey -= 4; frame(ex, ey, 1); end
    frame(600, 0, 1);
    frame(600, 0, 1);
    set_btn(0, 0, 0, 0);
    frame(600, 0, 0);

    // Async reset mid-ramp, two cycles before a vs edge
    set_btn(0, 0, 1, 0);
    frame(599, 0, 1);
    frame(598, 0, 1);
    vs = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(player_x), 300);
    chk("arst_y", int'(player_y), 0 + 220);
    chk("arst_tick", int'(frame_tick), 0);
    chk("arst_moving", int'(moving), 0);
    @(posedge pixel_clk); #1 vs = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1 btn_left = 1'b0;
    @(posedge pixel_clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge pixel_clk);
    #1;
    frame(300, 220, 0);

    repeat (10) @(posedge pixel_clk);
    #1;
    chk("pending_ticks", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Upstream stage of the VGA renderer. Produces the player square's top-left pixel position, which the renderer uses as its drawing offset.
- Synchronizes and debounces four raw direction buttons, then detects the frame boundary from the controller's VS output.
- Advances the position once per frame, with a two-level speed ramp and clamping to the 640x480 visible area.

Parameters:
- SIZE, 40, player square edge in pixels; sets the max position.
- START_X, 300, reset X position.
- START_Y, 220, reset Y position.
- SLOW_STEP, 1, pixels per frame in SLOW.
- FAST_STEP, 4, pixels per frame in FAST.
- RAMP_FRAMES, 8, consecutive moving frames in SLOW before entering FAST.
- DB_CYCLES, 250000, consecutive stable cycles needed to accept a button change (benches use 4).
- DB_W, 18, debounce counter width; must hold DB_CYCLES.

Ports:
- pixel_clk  in  1  25 MHz pixel clock, same clock as the VGA controller.
- rst_n  in  1  asynchronous active-low reset.
- btn_up  in  1  raw asynchronous button, active high.
- btn_down  in  1  raw asynchronous button, active high.
- btn_left  in  1  raw asynchronous button, active high.
- btn_right  in  1  raw asynchronous button, active high.
- vs  in  1  VS from the VGA controller, active-low pulse.
- player_x  out  11  player left edge, range 0..640-SIZE.
- player_y  out  11  player top edge, range 0..480-SIZE.
- frame_tick  out  1  one-cycle pulse on the cycle the position updates.
- moving  out  1  high when state is SLOW or FAST.

Behaviour:
- Reset (async assert, sync release):
  - player_x=START_X, player_y=START_Y.
  - frame_tick=0, moving=0, state=IDLE, ramp counter=0.
  - Sync flops=0, debounced buttons=0, debounce counters=0.
  - vs_d=1, so no false edge after release.
- Synchronizer: two flops per button. Debounce logic uses only the second-stage output.
- Debounce, per button:
  - If synced value equals the debounced value, the counter clears.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES clears the counter and never propagates.
- Frame edge:
  - vs_d registers vs every cycle. edge = vs & ~vs_d (rising edge, i.e. end of the VS pulse).
  - On the edge cycle's clock, frame_tick<=1 and the position, state and ramp counter update on the same edge. frame_tick is high for exactly one cycle.
- Axis direction, from debounced buttons:
  - dx = +1 for right only, -1 for left only, 0 for none or both.
  - dy = +1 for down only, -1 for up only, 0 for none or both.
  - any_move = (dx!=0) | (dy!=0).
- State machine, evaluated only on edge cycles:
  - IDLE: any_move -> SLOW with ramp counter=0; otherwise stays IDLE.
  - SLOW: !any_move -> IDLE. Otherwise, if ramp counter == RAMP_FRAMES-1 -> FAST; else the ramp counter increments.
  - FAST: !any_move -> IDLE with ramp counter=0; otherwise stays FAST.
  - The step applied on an edge uses the state after the transition: a frame entering SLOW moves SLOW_STEP, and a frame entering IDLE moves 0.
- Arithmetic:
  - Computed in 12-bit signed: next = pos + d*step.
  - If next < 0 the result is 0. If next > 640-SIZE (X) or 480-SIZE (Y) it is clamped to that max.
  - No wrap-around at any boundary.
  - Pressing toward a wall while clamped holds the position but stays in SLOW/FAST.
- moving reflects the registered state. It updates on the edge cycle together with the position.
- Between edges, position and state hold regardless of button activity.
- Reset mid-frame or mid-debounce returns everything to reset values immediately. The first edge after release is a normal update.

Test Plan (DB_CYCLES=4, RAMP_FRAMES=8, defaults otherwise):
- Reset: hold rst_n=0 with buttons high and vs toggling -> player_x=300, player_y=220, frame_tick=0, moving=0. After release, no frame_tick until the first vs rising edge.
- Debounce: btn_right high for 3 cycles then low -> position never changes. Hold it for 200 cycles spanning 2 vs rising edges -> player_x 301 then 302, moving=1.
- Ramp: hold btn_right across 12 frames -> x steps +1 for 8 frames (300→308), then +4 per frame (312, 316, 320, 324). Releasing it -> next frame moving=0, x holds.
- Clamp: start X at 598 in FAST holding right -> x=600 and stays 600 on later frames. At y=2 in FAST holding up -> y=0, never wraps to 2047.
- Conflict and diagonal: left+right held -> x unchanged and moving=0 with no vertical press. Right+down held in SLOW -> both axes +1 per frame.
- Async reset: assert rst_n mid-ramp, two cycles before a vs edge -> outputs return to reset values within the same cycle, and no frame_tick pulse is seen for that edge.
